// File: rtl/exp_1x1_pkg.sv
// Shared widths, FSM encoding and record types for the EXPAND 1x1 kernel RAM
// read/write controllers.
package exp_1x1_pkg;

  localparam int ADDR_W = 12;
  localparam int LAYR_W = 7;
  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_RDY = 2'd1;
  localparam logic [1:0] ST_READ     = 2'd2;

  // Per-word sideband that travels alongside the RAM read latency.
  typedef struct packed {
    logic              valid;
    logic              last;
    logic [LAYR_W-1:0] layer_no;
    logic              pass_done;
  } ker_tag_t;

  typedef struct packed {
    logic [1:0]        state;
    logic              pend;
    logic              first_pass;
    logic              calc_done;
    logic [LAYR_W-1:0] layer;
    logic [LAYR_W-1:0] word;
  } dbg_t;

endpackage

// File: rtl/exp_1x1_ker_read_cont_if.sv
// Kernel read bus: RAM read port plus the kernel word stream to the MAC engine.
interface exp_1x1_ker_read_cont_if;
  import exp_1x1_pkg::*;

  // layer_req_i asks for one full layer burst (pulse or level); it is not
  // back-pressured. ker_valid_o qualifies ker_data_o/ker_last_o/ker_layer_no_o
  // for exactly one cycle per word and cannot be stalled by the engine.
  logic              layer_req_i;
  logic [ADDR_W-1:0] exp_1x1_ram_rd_addr_o;
  logic              exp_1x1_ram_rd_en_o;
  logic [DATA_W-1:0] exp_1x1_ram_rd_data_i;
  logic [DATA_W-1:0] ker_data_o;
  logic              ker_valid_o;
  logic              ker_last_o;
  logic [LAYR_W-1:0] ker_layer_no_o;
  logic              pass_done_o;

  modport master (
    input  layer_req_i, exp_1x1_ram_rd_data_i,
    output exp_1x1_ram_rd_addr_o, exp_1x1_ram_rd_en_o,
    output ker_data_o, ker_valid_o, ker_last_o, ker_layer_no_o, pass_done_o
  );

  modport slave (
    output layer_req_i, exp_1x1_ram_rd_data_i,
    input  exp_1x1_ram_rd_addr_o, exp_1x1_ram_rd_en_o,
    input  ker_data_o, ker_valid_o, ker_last_o, ker_layer_no_o, pass_done_o
  );

endinterface

// File: rtl/exp_1x1_rd_tag_delay.sv
// Aligns the read-side word tags with RAM data: DEPTH-stage shift register
// with a synchronous flush that drops everything in flight.
module exp_1x1_rd_tag_delay
  import exp_1x1_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     flush,
    input  ker_tag_t tag_in,
    output ker_tag_t tag_out
);

    ker_tag_t pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/exp_1x1_ker_read_cont.sv
// EXPAND 1x1 kernel RAM read controller: streams one depth layer per request,
// gated by the writer's layer-ready count on the first pass, wrapping to layer 0.
module exp_1x1_ker_read_cont
  import exp_1x1_pkg::*;
#(
    parameter int RAM_LAT = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      exp_1x1_en_i,
    input  logic [ADDR_W-1:0]         tot_exp1_ker_addr_limit_i,
    input  logic [LAYR_W-1:0]         one_exp1_ker_addr_limit_i,
    input  logic [LAYR_W-1:0]         exp_1x1_layer_ready_no_i,
    exp_1x1_ker_read_cont_if.master   bus,
    output dbg_t                      dbg_o
);

    logic [1:0]        state;
    logic              pend;
    logic              first_pass;
    logic [LAYR_W-1:0] layer;
    logic [LAYR_W-1:0] word;
    logic [ADDR_W-1:0] base;
    logic [LAYR_W-1:0] ready_q;
    logic [LAYR_W-1:0] one_lim;
    logic [ADDR_W-1:0] tot_lim;
    logic [ADDR_W:0]   shadow;
    logic [LAYR_W:0]   n_layers;
    logic              calc_done;

    logic              clr;
    logic              req_ok;
    logic [ADDR_W-1:0] w_step;
    logic              last_word;
    logic              last_layer;
    logic [LAYR_W-1:0] next_layer;
    logic              next_first;
    logic              can_start;
    logic              can_chain;
    logic              enter_read;
    ker_tag_t          tag_in;
    ker_tag_t          tag_out;

    function automatic logic layer_ok(input logic fp, input logic [LAYR_W-1:0] lay,
                                      input logic [LAYR_W-1:0] rdy);
        return !fp || (lay < rdy);
    endfunction

    assign clr = rst_i | start_i;

    always_comb begin
        req_ok     = bus.layer_req_i & exp_1x1_en_i;
        w_step     = ADDR_W'(one_lim) + ADDR_W'(1);
        last_word  = (word == one_lim);
        last_layer = ({1'b0, layer} == (n_layers - (LAYR_W+1)'(1)));
        next_layer = last_layer ? '0 : layer + LAYR_W'(1);
        next_first = first_pass & ~last_layer;
        // The ready compare uses the registered count, so a same-cycle increment waits a cycle.
        can_start  = calc_done && layer_ok(first_pass, layer, ready_q);
        can_chain  = calc_done && layer_ok(next_first, next_layer, ready_q);
        enter_read = 1'b0;
        if (state == ST_WAIT_RDY && can_start) enter_read = 1'b1;
        if (state == ST_READ && last_word && pend && can_chain) enter_read = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tot_lim <= '0;
            one_lim <= '0;
        end else if (start_i) begin
            tot_lim <= tot_exp1_ker_addr_limit_i;
            one_lim <= one_exp1_ker_addr_limit_i;
        end
    end

    // Layer count L = (tot+1)/W found by stepping a shadow address by W.
    always_ff @(posedge clk_i) begin
        if (clr) begin
            shadow    <= '0;
            n_layers  <= '0;
            calc_done <= 1'b0;
            ready_q   <= '0;
        end else begin
            ready_q <= exp_1x1_layer_ready_no_i;
            if (!calc_done) begin
                if (shadow <= {1'b0, tot_lim}) begin
                    shadow   <= shadow + {1'b0, w_step};
                    n_layers <= n_layers + (LAYR_W+1)'(1);
                end else begin
                    calc_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr) begin
            state      <= ST_IDLE;
            pend       <= 1'b0;
            first_pass <= 1'b1;
            layer      <= '0;
            word       <= '0;
            base       <= '0;
        end else begin
            // A request in the entry cycle is kept so back-to-back bursts chain.
            pend <= req_ok | (pend & ~enter_read);
            case (state)
                ST_IDLE: begin
                    if (exp_1x1_en_i && (pend || bus.layer_req_i)) state <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (can_start) state <= ST_READ;
                end
                ST_READ: begin
                    if (last_word) begin
                        word       <= '0;
                        layer      <= next_layer;
                        first_pass <= next_first;
                        base       <= last_layer ? '0 : base + w_step;
                        if (pend && can_chain) state <= ST_READ;
                        else if (pend)         state <= ST_WAIT_RDY;
                        else                   state <= ST_IDLE;
                    end else begin
                        word <= word + LAYR_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.exp_1x1_ram_rd_en_o   = (state == ST_READ);
    assign bus.exp_1x1_ram_rd_addr_o = base + ADDR_W'(word);

    always_comb begin
        tag_in           = '0;
        tag_in.valid     = (state == ST_READ);
        tag_in.last      = (state == ST_READ) && last_word;
        tag_in.layer_no  = (state == ST_READ) ? layer : '0;
        tag_in.pass_done = (state == ST_READ) && last_word && last_layer;
    end

    exp_1x1_rd_tag_delay #(.DEPTH(RAM_LAT)) u_tag_delay (
        .clk     (clk_i),
        .flush   (clr),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign bus.ker_valid_o    = tag_out.valid;
    assign bus.ker_last_o     = tag_out.last;
    assign bus.ker_layer_no_o = tag_out.layer_no;
    assign bus.pass_done_o    = tag_out.pass_done;
    assign bus.ker_data_o     = tag_out.valid ? bus.exp_1x1_ram_rd_data_i : '0;

    always_comb begin
        dbg_o            = '0;
        dbg_o.state      = state;
        dbg_o.pend       = pend;
        dbg_o.first_pass = first_pass;
        dbg_o.calc_done  = calc_done;
        dbg_o.layer      = layer;
        dbg_o.word       = word;
    end

endmodule

// File: tb/tb_exp_1x1_ker_read_cont.sv
// Bench for the EXPAND 1x1 kernel read controller: transaction-level model of
// the word stream, directed scenarios and randomized configurations.
module tb_exp_1x1_ker_read_cont;
  import exp_1x1_pkg::*;

  localparam int EXP_W = 1 + 1 + LAYR_W + 1 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              start;
  logic              en;
  logic [ADDR_W-1:0] tot;
  logic [LAYR_W-1:0] one;
  logic [LAYR_W-1:0] ready_drv;
  dbg_t              dbg;

  exp_1x1_ker_read_cont_if bus_if ();

  exp_1x1_ker_read_cont #(.RAM_LAT(1)) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .start_i                   (start),
    .exp_1x1_en_i              (en),
    .tot_exp1_ker_addr_limit_i (tot),
    .one_exp1_ker_addr_limit_i (one),
    .exp_1x1_layer_ready_no_i  (ready_drv),
    .bus                       (bus_if),
    .dbg_o                     (dbg)
  );

  // RAM: word holds its own address in the top half for easy literal checks.
  logic [DATA_W-1:0] mem [4096];
  initial for (int a = 0; a < 4096; a++) mem[a] = {a[15:0], 16'($urandom)};
  always @(posedge clk)
    if (bus_if.exp_1x1_ram_rd_en_o) bus_if.exp_1x1_ram_rd_data_i <= mem[bus_if.exp_1x1_ram_rd_addr_o];

  // ---------------- model + scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q [$];
  int m_w, m_l, m_layer;
  bit m_fp;
  int reqs, rd_cycles, rd_base, req_cyc;
  bit rand_ready;

  typedef struct { int addr; bit last; bit pass; int cyc; } cap_t;
  cap_t cap_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One request yields the next layer's W words in address order.
  task automatic push_burst();
    for (int i = 0; i < m_w; i++) begin
      int a;
      bit lst, pd;
      a   = m_layer * m_w + i;
      lst = (i == m_w - 1);
      pd  = lst && (m_layer == m_l - 1);
      exp_q.push_back({m_fp, pd, LAYR_W'(m_layer), lst, mem[a]});
    end
    if (m_layer == m_l - 1) begin
      m_layer = 0;
      m_fp    = 1'b0;
    end else begin
      m_layer++;
    end
  endtask

  always @(negedge clk) if (bus_if.exp_1x1_ram_rd_en_o) rd_cycles++;
  always @(negedge clk)
    if (bus_if.ker_valid_o)
      cap_q.push_back('{int'(bus_if.ker_data_o[31:16]), bus_if.ker_last_o, bus_if.pass_done_o, cyc});

  bit prev_mid = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.ker_valid_o) begin
        logic [EXP_W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid: got data=%h with no word expected", bus_if.ker_data_o);
        end else begin
          e = exp_q.pop_front();
          if ({bus_if.pass_done_o, bus_if.ker_layer_no_o, bus_if.ker_last_o, bus_if.ker_data_o}
              !== e[EXP_W-2:0]) begin
            failures++;
            $display("FAIL word: got data=%h last=%0d layer=%0d pass=%0d required data=%h last=%0d layer=%0d pass=%0d",
                     bus_if.ker_data_o, bus_if.ker_last_o, bus_if.ker_layer_no_o, bus_if.pass_done_o,
                     e[DATA_W-1:0], e[DATA_W], e[DATA_W+LAYR_W:DATA_W+1], e[EXP_W-2]);
          end
          if (e[EXP_W-1]) begin
            checks++;
            if (int'(e[DATA_W+LAYR_W:DATA_W+1]) >= int'(ready_drv)) begin
              failures++;
              $display("FAIL ready_gate: got layer %0d read with ready count %0d",
                       e[DATA_W+LAYR_W:DATA_W+1], ready_drv);
            end
          end
        end
      end else begin
        checks++;
        if (bus_if.ker_last_o || bus_if.pass_done_o) begin
          failures++;
          $display("FAIL idle_tags: got last=%0d pass=%0d required 0 0", bus_if.ker_last_o, bus_if.pass_done_o);
        end
      end
      if (prev_mid) begin
        checks++;
        if (!bus_if.ker_valid_o) begin
          failures++;
          $display("FAIL burst_gap: got valid=0 required 1 inside a layer");
        end
      end
      prev_mid = bus_if.ker_valid_o && !bus_if.ker_last_o;
      if (start) begin
        prev_mid = 1'b0;
        exp_q.delete();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready && int'(ready_drv) < m_l && $urandom_range(0, 3) == 0) ready_drv = ready_drv + 1'b1;
  endtask

  task automatic do_start(input int w, input int l, input int rdy);
    tick();
    start = 1'b1;
    one = LAYR_W'(w - 1);
    tot = ADDR_W'(w * l - 1);
    ready_drv = LAYR_W'(rdy);
    tick();
    start = 1'b0;
    m_w = w; m_l = l; m_layer = 0; m_fp = 1'b1;
    reqs = 0; rd_base = rd_cycles;
  endtask

  task automatic do_req();
    int n;
    n = 0;
    while ((rd_cycles - rd_base + m_w - 1) / m_w < reqs && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("req_wait_timeout", 1, 0);
    tick();
    bus_if.layer_req_i = 1'b1;
    req_cyc = cyc;
    if (en) begin
      push_burst();
      reqs++;
    end
    tick();
    bus_if.layer_req_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_words_left", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cb, n, pcnt;
    rst = 1'b1; start = 1'b0; en = 1'b0; tot = '0; one = '0; ready_drv = '0;
    bus_if.layer_req_i = 1'b0;
    bus_if.exp_1x1_ram_rd_data_i = '0;
    rand_ready = 1'b0; m_w = 1; m_l = 1; m_layer = 0; m_fp = 1'b1;
    reqs = 0; rd_cycles = 0; rd_base = 0; req_cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus_if.ker_valid_o, 0);
    chk("rst_rd_en", bus_if.exp_1x1_ram_rd_en_o, 0);
    chk("rst_pass", bus_if.pass_done_o, 0);
    chk("rst_data", bus_if.ker_data_o, 0);
    chk("rst_state", dbg.state, ST_IDLE);
    tick();
    rst = 1'b0;
    en = 1'b1;

    // T1: single request, W=4 L=4
    do_start(4, 4, 4);
    repeat (20) tick();
    cb = cap_q.size();
    do_req();
    wait_drain(100);
    chk("t1_count", cap_q.size() - cb, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", cap_q[cb+i].addr, i);
      chk("t1_last", cap_q[cb+i].last, (i == 3));
    end
    chk("t1_latency", cap_q[cb].cyc - req_cyc, 3);

    // T2: layer not ready yet
    do_start(4, 4, 0);
    repeat (20) tick();
    do_req();
    repeat (10) tick();
    chk("t2_stall_rd", rd_cycles - rd_base, 0);
    chk("t2_state", dbg.state, ST_WAIT_RDY);
    ready_drv = 1;
    wait_drain(100);
    do_req();
    repeat (10) tick();
    chk("t2_stall2_rd", rd_cycles - rd_base, 4);
    ready_drv = 2;
    wait_drain(100);
    chk("t2_rd_total", rd_cycles - rd_base, 8);

    // T3: back-to-back full pass, then a second-pass request with no ready
    do_start(4, 4, 4);
    repeat (20) tick();
    cb = cap_q.size();
    for (int r = 0; r < 4; r++) do_req();
    wait_drain(200);
    chk("t3_count", cap_q.size() - cb, 16);
    chk("t3_no_gap", cap_q[cb+15].cyc - cap_q[cb].cyc, 15);
    pcnt = 0;
    for (int i = 0; i < 16; i++) pcnt += cap_q[cb+i].pass;
    chk("t3_pass_cnt", pcnt, 1);
    chk("t3_pass_w15", cap_q[cb+15].pass, 1);
    ready_drv = 0;
    cb = cap_q.size();
    do_req();
    wait_drain(100);
    chk("t3_wrap_count", cap_q.size() - cb, 4);
    chk("t3_wrap_a0", cap_q[cb].addr, 0);
    chk("t3_wrap_a3", cap_q[cb+3].addr, 3);

    // T4: start during word 2 of layer 1
    do_start(4, 4, 4);
    repeat (20) tick();
    do_req();
    do_req();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus_if.exp_1x1_ram_rd_en_o && bus_if.exp_1x1_ram_rd_addr_o == 5) && n < 100);
    chk("t4_found_addr5", (n < 100), 1);
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    chk("t4_addr_at_start", bus_if.exp_1x1_ram_rd_addr_o, 6);
    @(posedge clk); #1;
    start = 1'b0;
    m_layer = 0; m_fp = 1'b1; reqs = 0; rd_base = rd_cycles;
    chk("t4_rd_en", bus_if.exp_1x1_ram_rd_en_o, 0);
    chk("t4_valid", bus_if.ker_valid_o, 0);
    chk("t4_addr", bus_if.exp_1x1_ram_rd_addr_o, 0);
    chk("t4_layer", dbg.layer, 0);
    chk("t4_first_pass", dbg.first_pass, 1);
    repeat (6) tick();
    chk("t4_no_read", rd_cycles - rd_base, 0);

    // T5: W=1, L=3
    do_start(1, 3, 3);
    repeat (20) tick();
    cb = cap_q.size();
    for (int r = 0; r < 4; r++) do_req();
    wait_drain(100);
    chk("t5_count", cap_q.size() - cb, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t5_addr", cap_q[cb+i].addr, (i == 3) ? 0 : i);
      chk("t5_last", cap_q[cb+i].last, 1);
      chk("t5_pass", cap_q[cb+i].pass, (i == 2));
    end

    // T6: path disabled
    en = 1'b0;
    do_start(4, 4, 4);
    repeat (20) tick();
    for (int r = 0; r < 3; r++) do_req();
    repeat (10) tick();
    chk("t6_off_rd", rd_cycles - rd_base, 0);
    en = 1'b1;
    repeat (10) tick();
    chk("t6_en_rd", rd_cycles - rd_base, 0);
    do_req();
    wait_drain(100);
    chk("t6_after_req_rd", rd_cycles - rd_base, 4);

    // Randomized configurations with a writer filling layers over time
    for (int it = 0; it < 25; it++) begin
      int w, l, nr;
      w = $urandom_range(1, 8);
      l = $urandom_range(1, 6);
      do_start(w, l, $urandom_range(0, l));
      rand_ready = 1'b1;
      nr = $urandom_range(1, 3 * l);
      for (int r = 0; r < nr; r++) begin
        do_req();
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_drain(2000);
      rand_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
